// File: rtl/pipe_ctrl_if.sv
// Pipeline <-> stall/flush controller bundle.
// Master is the pipeline side, slave is pipe_ctrl.
interface pipe_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             stallreq_if_i;
    logic             stallreq_id_i;
    logic             stallreq_ex_i;
    logic             stallreq_mem_i;
    logic             exc_req_i;
    logic             eret_i;
    logic [31:0]      epc_i;
    logic [5:0]       stall_o;
    logic             flush_o;
    logic [31:0]      new_pc_o;
    logic             div_cancel_o;
    logic             timeout_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport master (
        output stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
        output exc_req_i, eret_i, epc_i,
        input  stall_o, flush_o, new_pc_o, div_cancel_o,
        input  timeout_o, stall_cnt_o
    );

    modport slave (
        input  stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
        input  exc_req_i, eret_i, epc_i,
        output stall_o, flush_o, new_pc_o, div_cancel_o,
        output timeout_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Stall/flush controller for the 5-stage pipeline.
// Zero-latency flush, post-flush mask, watchdog, stall counter.
module pipe_ctrl #(
    parameter logic [31:0] EXC_BASE      = 32'h0000_0180,
    parameter int          MASK_CYCLES   = 3,
    parameter int          STALL_TIMEOUT = 1024,
    parameter int          CNT_W         = 32
) (
    input logic         clk,
    input logic         rst,
    pipe_ctrl_if.slave  bus
);
    localparam int WD_W = (STALL_TIMEOUT < 2) ? 1
                        : $clog2(STALL_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST =
        WD_W'((STALL_TIMEOUT > 0) ? STALL_TIMEOUT - 1 : 0);
    localparam logic [3:0] MASK_LOAD = 4'(MASK_CYCLES);

    typedef enum logic [0:0] {
        RUN,
        MASK
    } state_t;

    state_t           state;
    logic [3:0]       mask_cnt;
    logic [WD_W-1:0]  wd_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic             timeout;
    logic             flush;
    logic [5:0]       stall;
    logic [31:0]      new_pc;
    logic             stalled;

    // Flush fires in the same cycle as the request, only while unmasked.
    always_comb begin
        flush = (bus.exc_req_i | bus.eret_i) & (state == RUN) & ~rst;
    end

    // Redirect target: exception beats ERET when both arrive together.
    always_comb begin
        new_pc = 32'h0;
        if (!rst) begin
            if (bus.exc_req_i) begin
                new_pc = EXC_BASE;
            end else if (bus.eret_i) begin
                new_pc = bus.epc_i;
            end
        end
    end

    // Stall vector: the deepest requesting stage freezes everything before it.
    always_comb begin
        stall = 6'b000000;
        if (!rst && !flush) begin
            priority case (1'b1)
                bus.stallreq_mem_i: stall = 6'b011111;
                bus.stallreq_ex_i:  stall = 6'b001111;
                bus.stallreq_id_i:  stall = 6'b000111;
                bus.stallreq_if_i:  stall = 6'b000011;
                default:            stall = 6'b000000;
            endcase
        end
    end

    assign stalled = |stall;

    // Mode FSM, mask countdown, watchdog and saturating stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            mask_cnt  <= 4'd0;
            wd_cnt    <= '0;
            stall_cnt <= '0;
            timeout   <= 1'b0;
        end else begin
            timeout <= 1'b0;

            if (stalled && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end

            unique case (state)
                RUN: begin
                    if (flush) begin
                        state    <= MASK;
                        mask_cnt <= MASK_LOAD;
                    end
                end
                MASK: begin
                    if (mask_cnt <= 4'd1) begin
                        state    <= RUN;
                        mask_cnt <= 4'd0;
                    end else begin
                        mask_cnt <= mask_cnt - 4'd1;
                    end
                end
            endcase

            // A flush cycle never stalls, so it clears the watchdog here too.
            if (!stalled || STALL_TIMEOUT == 0) begin
                wd_cnt <= '0;
            end else if (wd_cnt == WD_LAST) begin
                wd_cnt  <= '0;
                timeout <= 1'b1;
            end else begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
        end
    end

    assign bus.stall_o      = stall;
    assign bus.flush_o      = flush;
    assign bus.new_pc_o     = new_pc;
    assign bus.div_cancel_o = flush;
    assign bus.timeout_o    = timeout;
    assign bus.stall_cnt_o  = stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl.
// dut_a: watchdog at 8; dut_b: 4-bit counter, watchdog off.
module tb_pipe_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pipe_ctrl_if #(.CNT_W(32)) bus_a ();
    pipe_ctrl_if #(.CNT_W(4))  bus_b ();

    pipe_ctrl #(
        .EXC_BASE     (32'h0000_0180),
        .MASK_CYCLES  (3),
        .STALL_TIMEOUT(8),
        .CNT_W        (32)
    ) dut_a (
        .clk(clk),
        .rst(rst),
        .bus(bus_a)
    );

    pipe_ctrl #(
        .EXC_BASE     (32'h0000_0180),
        .MASK_CYCLES  (3),
        .STALL_TIMEOUT(0),
        .CNT_W        (4)
    ) dut_b (
        .clk(clk),
        .rst(rst),
        .bus(bus_b)
    );

    assign bus_b.stallreq_if_i  = bus_a.stallreq_if_i;
    assign bus_b.stallreq_id_i  = bus_a.stallreq_id_i;
    assign bus_b.stallreq_ex_i  = bus_a.stallreq_ex_i;
    assign bus_b.stallreq_mem_i = bus_a.stallreq_mem_i;
    assign bus_b.exc_req_i      = bus_a.exc_req_i;
    assign bus_b.eret_i         = bus_a.eret_i;
    assign bus_b.epc_i          = bus_a.epc_i;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus_a.stallreq_if_i  = 1'b0;
        bus_a.stallreq_id_i  = 1'b0;
        bus_a.stallreq_ex_i  = 1'b0;
        bus_a.stallreq_mem_i = 1'b0;
        bus_a.exc_req_i      = 1'b0;
        bus_a.eret_i         = 1'b0;
        bus_a.epc_i          = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_a.stallreq_mem_i = 1'b1;
        bus_a.exc_req_i      = 1'b1;
        bus_a.eret_i         = 1'b1;
        bus_a.epc_i          = 32'hdead_beef;
        #1;
        checks++;
        if (bus_a.stall_o !== 6'b000000 || bus_a.flush_o !== 1'b0 ||
            bus_a.div_cancel_o !== 1'b0 || bus_a.new_pc_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_comb: stall=%b flush=%b div=%b pc=%h want 0",
                     bus_a.stall_o, bus_a.flush_o, bus_a.div_cancel_o,
                     bus_a.new_pc_o);
        end
        tick();
        clear_inputs();
        rst = 1'b0;
        #1;
        checks++;
        if (bus_a.stall_cnt_o !== 32'd0 || bus_a.timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs: cnt=%0d to=%b want 0 0",
                     bus_a.stall_cnt_o, bus_a.timeout_o);
        end
    endtask

    task automatic test_priority();
        bus_a.stallreq_if_i  = 1'b1;
        bus_a.stallreq_mem_i = 1'b1;
        #1;
        checks++;
        if (bus_a.stall_o !== 6'b011111) begin
            errors++;
            $display("FAIL prio_mem: stall=%b want 011111", bus_a.stall_o);
        end
        tick();
        bus_a.stallreq_mem_i = 1'b0;
        #1;
        checks++;
        if (bus_a.stall_o !== 6'b000011) begin
            errors++;
            $display("FAIL prio_if: stall=%b want 000011", bus_a.stall_o);
        end
        bus_a.stallreq_id_i = 1'b1;
        #1;
        checks++;
        if (bus_a.stall_o !== 6'b000111) begin
            errors++;
            $display("FAIL prio_id: stall=%b want 000111", bus_a.stall_o);
        end
        bus_a.stallreq_ex_i = 1'b1;
        #1;
        checks++;
        if (bus_a.stall_o !== 6'b001111) begin
            errors++;
            $display("FAIL prio_ex: stall=%b want 001111", bus_a.stall_o);
        end
        clear_inputs();
        #1;
        checks++;
        if (bus_a.stall_o !== 6'b000000) begin
            errors++;
            $display("FAIL prio_none: stall=%b want 000000", bus_a.stall_o);
        end
        tick();
    endtask

    task automatic test_exc_flush();
        logic        f_exp;
        logic [5:0]  s_exp;
        bus_a.stallreq_ex_i = 1'b1;
        bus_a.exc_req_i     = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            f_exp = (c == 0 || c == 4);
            s_exp = f_exp ? 6'b000000 : 6'b001111;
            checks++;
            if (bus_a.flush_o !== f_exp || bus_a.div_cancel_o !== f_exp ||
                bus_a.stall_o !== s_exp) begin
                errors++;
                $display("FAIL exc_cycle%0d: flush=%b div=%b stall=%b want %b %b %b",
                         c, bus_a.flush_o, bus_a.div_cancel_o, bus_a.stall_o,
                         f_exp, f_exp, s_exp);
            end
            if (f_exp) begin
                checks++;
                if (bus_a.new_pc_o !== 32'h0000_0180) begin
                    errors++;
                    $display("FAIL exc_pc%0d: pc=%h want 00000180",
                             c, bus_a.new_pc_o);
                end
            end
            tick();
        end
        clear_inputs();
        repeat (3) tick();
    endtask

    task automatic test_exc_eret();
        bus_a.exc_req_i = 1'b1;
        bus_a.eret_i    = 1'b1;
        bus_a.epc_i     = 32'h0040_1000;
        #1;
        checks++;
        if (bus_a.new_pc_o !== 32'h0000_0180 || bus_a.flush_o !== 1'b1) begin
            errors++;
            $display("FAIL both_pc: pc=%h flush=%b want 00000180 1",
                     bus_a.new_pc_o, bus_a.flush_o);
        end
        tick();
        bus_a.exc_req_i = 1'b0;
        #1;
        checks++;
        if (bus_a.flush_o !== 1'b0) begin
            errors++;
            $display("FAIL eret_masked: flush=%b want 0", bus_a.flush_o);
        end
        bus_a.eret_i = 1'b0;
        repeat (3) tick();
        bus_a.eret_i = 1'b1;
        #1;
        checks++;
        if (bus_a.new_pc_o !== 32'h0040_1000 || bus_a.flush_o !== 1'b1) begin
            errors++;
            $display("FAIL eret_pc: pc=%h flush=%b want 00401000 1",
                     bus_a.new_pc_o, bus_a.flush_o);
        end
        tick();
        clear_inputs();
        repeat (3) tick();
    endtask

    task automatic test_watchdog();
        logic to_exp;
        do_reset();
        bus_a.stallreq_id_i = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            to_exp = (i == 8 || i == 16);
            checks++;
            if (bus_a.timeout_o !== to_exp) begin
                errors++;
                $display("FAIL wd_edge%0d: timeout=%b want %b",
                         i, bus_a.timeout_o, to_exp);
            end
            checks++;
            if (bus_b.timeout_o !== 1'b0) begin
                errors++;
                $display("FAIL wd_off%0d: timeout=%b want 0",
                         i, bus_b.timeout_o);
            end
            if (i == 14 || i == 15 || i == 20) begin
                checks++;
                if (bus_b.stall_cnt_o !== ((i == 14) ? 4'hE : 4'hF)) begin
                    errors++;
                    $display("FAIL sat_cnt%0d: cnt=%h want %h", i,
                             bus_b.stall_cnt_o, (i == 14) ? 4'hE : 4'hF);
                end
            end
        end
        bus_a.stallreq_id_i = 1'b0;
        checks++;
        if (bus_a.stall_cnt_o !== 32'd20) begin
            errors++;
            $display("FAIL stall_cnt: cnt=%0d want 20", bus_a.stall_cnt_o);
        end
        tick();
    endtask

    task automatic test_wd_idle();
        do_reset();
        bus_a.stallreq_id_i = 1'b1;
        repeat (7) tick();
        bus_a.stallreq_id_i = 1'b0;
        tick();
        checks++;
        if (bus_a.timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL wd_idle: timeout=%b want 0", bus_a.timeout_o);
        end
        bus_a.stallreq_id_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (bus_a.timeout_o !== (i == 8)) begin
                errors++;
                $display("FAIL wd_restart%0d: timeout=%b want %b",
                         i, bus_a.timeout_o, (i == 8));
            end
        end
        bus_a.stallreq_id_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        bus_a.exc_req_i = 1'b1;
        tick();
        bus_a.stallreq_mem_i = 1'b1;
        rst = 1'b1;
        #1;
        checks++;
        if (bus_a.stall_o !== 6'b000000 || bus_a.flush_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: stall=%b flush=%b want 000000 0",
                     bus_a.stall_o, bus_a.flush_o);
        end
        tick();
        rst = 1'b0;
        bus_a.stallreq_mem_i = 1'b0;
        #1;
        checks++;
        if (bus_a.flush_o !== 1'b1 || bus_a.stall_cnt_o !== 32'd0 ||
            bus_a.timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_after: flush=%b cnt=%0d to=%b want 1 0 0",
                     bus_a.flush_o, bus_a.stall_cnt_o, bus_a.timeout_o);
        end
        tick();
        clear_inputs();
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        clear_inputs();
        tick();
        test_reset();
        test_priority();
        test_exc_flush();
        test_exc_eret();
        test_watchdog();
        test_wd_idle();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush controller for the 5-stage MIPS32 pipeline. It drives the hold and clear of every pipeline register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Collects per-stage stall requests plus exception/ERET requests and produces a stall vector, a flush pulse and a redirect PC.
- Masks re-triggering for a few cycles after a flush.
- Provides a stall-timeout watchdog and a saturating stall-cycle performance counter.

Parameters:
- EXC_BASE, 32'h0000_0180: redirect PC for exceptions.
- MASK_CYCLES, 3: cycles after a flush during which exc_req_i/eret_i are ignored; range 1..15.
- STALL_TIMEOUT, 1024: consecutive stalled cycles that raise timeout_o; 0 disables the watchdog.
- CNT_W, 32: width of stall_cnt_o.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: reset, synchronous, active-high.
- stallreq_if_i, input, 1: fetch waiting on instruction bus.
- stallreq_id_i, input, 1: load-use hazard.
- stallreq_ex_i, input, 1: multi-cycle mul/div busy.
- stallreq_mem_i, input, 1: data bus wait.
- exc_req_i, input, 1: exception committed in MEM.
- eret_i, input, 1: ERET committed in MEM.
- epc_i, input, 32: return address for ERET.
- stall_o, output, 6: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
- flush_o, output, 1: clear all pipeline registers this cycle.
- new_pc_o, output, 32: redirect target, valid when flush_o=1.
- div_cancel_o, output, 1: abort in-flight divide; equals flush_o.
- timeout_o, output, 1: one-cycle watchdog pulse.
- stall_cnt_o, output, CNT_W: saturating count of stalled cycles.

Behaviour:
- State register: RUN, MASK. A mask counter (4 bits) and a watchdog counter (width clog2(STALL_TIMEOUT+1), min 1) are also registered.
- Reset (rst=1 at a clock edge) sets: state=RUN, mask counter=0, watchdog=0, stall_cnt_o=0, timeout_o=0.
- While rst is high, the combinational outputs stall_o, flush_o and div_cancel_o are forced to 0, and new_pc_o is forced to 0.
- Reset asserted mid-flush or mid-stall discards all pending state; no pulse is generated after reset.
- Flush condition, combinational: flush_o = (exc_req_i | eret_i) & state==RUN & !rst. It is asserted in the same cycle as the request, with zero latency.
- new_pc_o is EXC_BASE if exc_req_i=1, else epc_i if eret_i=1, else 0. When exc_req_i and eret_i arrive together, the exception wins.
- When flush_o=1:
  - stall_o = 6'b000000.
  - state -> MASK and mask counter loads MASK_CYCLES.
  - watchdog clears.
- In MASK:
  - exc_req_i/eret_i are ignored; flush_o = 0.
  - Stall logic operates normally.
  - The counter decrements each cycle; at 1 -> RUN on the next edge.
  - A request arriving on the first RUN cycle is accepted.
- Stall vector (combinational, when flush_o=0, highest requesting stage wins):
  - mem -> 6'b011111
  - ex -> 6'b001111
  - id -> 6'b000111
  - if -> 6'b000011
  - none -> 6'b000000
- Register convention for the consuming pipeline registers, for the register between stage k and k+1:
  - stall[k] & stall[k+1]: hold.
  - stall[k] & !stall[k+1]: load bubble.
  - Otherwise: advance.
- Watchdog:
  - Increments on every cycle with stall_o!=0 and clears on any cycle with stall_o==0.
  - On the edge where it would reach STALL_TIMEOUT, timeout_o=1 for the following cycle and the counter restarts at 0.
  - Stays silent if STALL_TIMEOUT=0.
- stall_cnt_o increments on every cycle with stall_o!=0 and saturates at all-ones; no wrap.
- timeout_o is registered. All other outputs except stall_cnt_o are combinational from inputs and state.

Test Plan:
- Priority: stallreq_if_i=1 and stallreq_mem_i=1 together -> stall_o=6'b011111. Release mem only -> stall_o=6'b000011 on that cycle.
- Exception flush: exc_req_i=1 for 5 cycles with stallreq_ex_i=1 -> cycle0 flush_o=1, div_cancel_o=1, new_pc_o=32'h180, stall_o=0. Cycles 1–3 flush_o=0, stall_o=6'b001111. Cycle 4 flush_o=1 again.
- Simultaneous exc/eret: exc_req_i=1, eret_i=1, epc_i=32'h0040_1000 -> new_pc_o=32'h0000_0180. ERET alone -> new_pc_o=32'h0040_1000.
- Watchdog: STALL_TIMEOUT=8, stallreq_id_i held 20 cycles -> timeout_o pulses after the 8th and 16th stalled cycles. stall_cnt_o=20 afterwards.
- Watchdog reset and saturation: a single idle cycle at count 7 -> no pulse, count restarts. CNT_W=4 with 20 stall cycles -> stall_cnt_o=4'hF.
- Reset mid-operation: rst asserted in MASK with stall requests active -> that cycle stall_o=0, flush_o=0. Next cycle state RUN, stall_cnt_o=0, and exc_req_i is accepted immediately.
